// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port RAM: last-served tie-break, back-to-back handover between owners.
// Optional burst limit preempts an owner after BURST_MAX transfers; enabled by defining ARB_BURST_LIMIT_EN.
module mem_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int BURST_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m0_we,
    input  logic          m1_we,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    // state | meaning
    // IDLE  | no owner, RAM side driven to zero
    // OWN0  | m0 owns the bus, m0_gnt=1
    // OWN1  | m1 owns the bus, m1_gnt=1
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    if (BURST_MAX < 2 || BURST_MAX > 255) begin : g_burst_max_check
        $error("mem_arbiter: BURST_MAX must be in 2..255");
    end

    state_t state;
    state_t state_next;
    logic   last_m1;
    logic   xfer0;
    logic   xfer1;
    logic   owner_we;
    logic   entering;
    logic   burst_done;
    logic   rd_pend;
    logic   rd_tag;

    assign m0_gnt = (state == OWN0);
    assign m1_gnt = (state == OWN1);
    assign xfer0  = m0_gnt && m0_req;
    assign xfer1  = m1_gnt && m1_req;
    assign rdata  = mem_rdata;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        owner_we  = 1'b0;
        case (state)
            OWN0: begin
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
                owner_we  = m0_we;
            end
            OWN1: begin
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
                owner_we  = m1_we;
            end
            default: begin
                mem_addr  = '0;
                mem_wdata = '0;
                owner_we  = 1'b0;
            end
        endcase
    end

    assign mem_we = (xfer0 || xfer1) && owner_we;

`ifdef ARB_BURST_LIMIT_EN
    localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

    logic [7:0] xfer_cnt;

    // burst_done flags that the transfer in progress is at least the BURST_MAX-th
    assign burst_done = (xfer_cnt >= BURST_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt <= 8'd0;
        end else if (entering) begin
            xfer_cnt <= 8'd0;
        end else if ((xfer0 || xfer1) && (xfer_cnt != 8'hFF)) begin
            xfer_cnt <= xfer_cnt + 8'd1;
        end
    end
`else
    assign burst_done = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_next = last_m1 ? OWN0 : OWN1;
                end else if (m0_req) begin
                    state_next = OWN0;
                end else if (m1_req) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                if (!m0_req) begin
                    state_next = m1_req ? OWN1 : IDLE;
                end else if (burst_done && m1_req) begin
                    state_next = OWN1;
                end
            end
            OWN1: begin
                if (!m1_req) begin
                    state_next = m0_req ? OWN0 : IDLE;
                end else if (burst_done && m0_req) begin
                    state_next = OWN0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign entering = (state_next != state) && (state_next != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // last_m1 resets high so m0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_m1 <= 1'b1;
        end else if (entering) begin
            last_m1 <= (state_next == OWN1);
        end
    end

    // The tag records who issued the read, so rvalid follows a handover correctly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            rd_tag  <= 1'b0;
        end else begin
            rd_pend <= (xfer0 || xfer1) && !owner_we;
            rd_tag  <= m1_gnt;
        end
    end

    assign m0_rvalid = rd_pend && !rd_tag;
    assign m1_rvalid = rd_pend && rd_tag;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against an ownership model.
// Expectations follow ARB_BURST_LIMIT_EN when the bench is built with it.
module tb_mem_arbiter;
    localparam int AW        = 16;
    localparam int DW        = 16;
    localparam int BURST_MAX = 8;
`ifdef ARB_BURST_LIMIT_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif
    localparam int HOLD_CYCLES = 24;
    localparam int EXP_M0_XFERS = BURST_EN ? BURST_MAX : HOLD_CYCLES;
    localparam int EXP_SEEN_M1  = BURST_EN ? 1 : 0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m1_req = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_we = 1'b0, m1_we = 1'b0;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    mem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_we(m0_we), .m1_we(m1_we),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return DW'(a * 16'd3) ^ 16'hA5C3;
    endfunction

    // RAM environment: one-cycle read latency, read-before-write
    logic [DW-1:0] ram [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) ram[i] = init_val(AW'(i));
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: who owns the bus, who was served last, transfers this tenure
    int            own;
    int            last;
    int            cnt;
    bit            rv_exp [2];
    logic [DW-1:0] rd_exp;
    logic [DW-1:0] shadow [int];

    function automatic logic req_of(input int i);  return (i == 0) ? m0_req : m1_req; endfunction
    function automatic logic we_of(input int i);   return (i == 0) ? m0_we : m1_we; endfunction
    function automatic logic [AW-1:0] addr_of(input int i);  return (i == 0) ? m0_addr : m1_addr; endfunction
    function automatic logic [DW-1:0] wdata_of(input int i); return (i == 0) ? m0_wdata : m1_wdata; endfunction
    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a);
    endfunction

    task automatic model_reset();
        own = -1; last = 1; cnt = 0; rv_exp[0] = 0; rv_exp[1] = 0;
    endtask

    task automatic model_step();
        bit xfer;
        int nxt;
        xfer = (own >= 0) && req_of(own);
        rv_exp[0] = 0; rv_exp[1] = 0;
        if (xfer && !we_of(own)) begin
            rv_exp[own] = 1;
            rd_exp = mem_model(addr_of(own));
        end
        if (xfer && we_of(own)) shadow[int'(addr_of(own))] = wdata_of(own);
        if (own < 0) begin
            if (m0_req && m1_req) nxt = 1 - last;
            else if (m0_req)      nxt = 0;
            else if (m1_req)      nxt = 1;
            else                  nxt = -1;
        end else if (!req_of(own)) begin
            nxt = req_of(1 - own) ? 1 - own : -1;
        end else if (BURST_EN && (cnt + 1 >= BURST_MAX) && req_of(1 - own)) begin
            nxt = 1 - own;
        end else begin
            nxt = own;
        end
        if (nxt >= 0 && nxt != own) begin
            last = nxt;
            cnt = 0;
        end else if (xfer && cnt < 255) begin
            cnt++;
        end
        own = nxt;
    endtask

    logic          s_gnt0, s_gnt1, s_rv0, s_rv1;
    logic [DW-1:0] s_rdata;
    logic [AW-1:0] s_addr;

    task automatic cycle();
        bit xfer;
        @(negedge clk);
        s_gnt0 = m0_gnt; s_gnt1 = m1_gnt; s_rv0 = m0_rvalid; s_rv1 = m1_rvalid;
        s_rdata = rdata; s_addr = mem_addr;
        xfer = (own >= 0) && req_of(own);
        chk("gnt0", 32'(m0_gnt), 32'(own == 0));
        chk("gnt1", 32'(m1_gnt), 32'(own == 1));
        chk("mem_addr", 32'(mem_addr), (own < 0) ? 32'd0 : 32'(addr_of(own)));
        chk("mem_wdata", 32'(mem_wdata), (own < 0) ? 32'd0 : 32'(wdata_of(own)));
        chk("mem_we", 32'(mem_we), 32'(xfer && we_of(own)));
        chk("rvalid0", 32'(m0_rvalid), 32'(rv_exp[0]));
        chk("rvalid1", 32'(m1_rvalid), 32'(rv_exp[1]));
        if (rv_exp[0] || rv_exp[1]) chk("rdata", 32'(rdata), 32'(rd_exp));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_m(input int i, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (i == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    initial begin
        int n0;
        bit seen1;
        model_reset();

        // reset values while rst is held
        @(posedge clk); #1;
        chk("rst_gnt0", 32'(m0_gnt), 32'd0);
        chk("rst_gnt1", 32'(m1_gnt), 32'd0);
        chk("rst_rv", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;

        // simultaneous requests after reset: m0 first, then m1 without an IDLE gap
        set_m(0, 1, 0, 16'h0020, 16'h0);
        set_m(1, 1, 0, 16'h0030, 16'h0);
        cycle();
        chk("tie_idle_gnt0", 32'(s_gnt0), 32'd0);
        cycle();
        chk("tie_gnt0", 32'(s_gnt0), 32'd1);
        chk("tie_gnt1_low", 32'(s_gnt1), 32'd0);
        cycle();
        set_m(0, 0, 0, 16'h0, 16'h0);
        cycle();
        cycle();
        chk("handover_gnt1", 32'(s_gnt1), 32'd1);
        set_m(1, 0, 0, 16'h0, 16'h0);
        cycle(); cycle(); cycle();

        // single read from IDLE
        set_m(0, 1, 0, 16'h0010, 16'h0);
        cycle();
        chk("rd_lat_idle", 32'(s_gnt0), 32'd0);
        cycle();
        chk("rd_gnt", 32'(s_gnt0), 32'd1);
        chk("rd_addr", 32'(s_addr), 32'h0010);
        set_m(0, 0, 0, 16'h0, 16'h0);
        cycle();
        chk("rd_rvalid", 32'(s_rv0), 32'd1);
        chk("rd_data", 32'(s_rdata), 32'(init_val(16'h0010)));
        cycle();

        // m1 write then m0 read-back
        set_m(1, 1, 1, 16'h0100, 16'hBEEF);
        cycle(); cycle();
        set_m(1, 0, 0, 16'h0, 16'h0);
        cycle(); cycle();
        set_m(0, 1, 0, 16'h0100, 16'h0);
        cycle(); cycle();
        set_m(0, 0, 0, 16'h0, 16'h0);
        cycle();
        chk("wb_rvalid", 32'(s_rv0), 32'd1);
        chk("wb_rdata", 32'(s_rdata), 32'hBEEF);
        cycle();

        // m0 holds req while m1 waits
        set_m(0, 1, 0, 16'h0040, 16'h0);
        cycle();
        set_m(1, 1, 0, 16'h0080, 16'h0);
        n0 = 0; seen1 = 0;
        for (int k = 0; k < HOLD_CYCLES; k++) begin
            cycle();
            if (!seen1) begin
                if (s_gnt1) begin
                    seen1 = 1;
                    chk("preempt_gnt0_low", 32'(s_gnt0), 32'd0);
                end else if (s_gnt0 && m0_req) begin
                    n0++;
                end
            end
            m0_addr = m0_addr + 16'd1;
        end
        chk("burst_m0_xfers", 32'(n0), 32'(EXP_M0_XFERS));
        chk("burst_m1_granted", 32'(seen1), 32'(EXP_SEEN_M1));
        set_m(0, 0, 0, 16'h0, 16'h0);
        set_m(1, 0, 0, 16'h0, 16'h0);
        cycle(); cycle(); cycle();

        // reset during an m1 read
        set_m(1, 1, 0, 16'h0050, 16'h0);
        cycle(); cycle();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_gnt1", 32'(m1_gnt), 32'd0);
        chk("mid_rst_rv1", 32'(m1_rvalid), 32'd0);
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        set_m(0, 1, 0, 16'h0060, 16'h0);
        set_m(1, 1, 0, 16'h0070, 16'h0);
        cycle();
        chk("post_rst_rv1", 32'(s_rv1), 32'd0);
        cycle();
        chk("post_rst_tie_gnt0", 32'(s_gnt0), 32'd1);
        set_m(0, 0, 0, 16'h0, 16'h0);
        set_m(1, 0, 0, 16'h0, 16'h0);
        cycle(); cycle(); cycle();

        // random traffic on a small address window so reads hit earlier writes
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) < 3) m0_req = ~m0_req;
            if ($urandom_range(0, 9) < 3) m1_req = ~m1_req;
            m0_addr  = AW'(16'h0200 + 16 * $urandom_range(0, 7));
            m1_addr  = AW'(16'h0200 + 16 * $urandom_range(0, 7));
            m0_we    = 1'($urandom_range(0, 1));
            m1_we    = 1'($urandom_range(0, 1));
            m0_wdata = DW'($urandom);
            m1_wdata = DW'($urandom);
            cycle();
        end
        set_m(0, 0, 0, 16'h0, 16'h0);
        set_m(1, 0, 0, 16'h0, 16'h0);
        cycle(); cycle(); cycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, address width.
REQ-002 SHALL have parameter DW, default 16, data width.
REQ-003 SHALL have parameter BURST_MAX, default 8, maximum consecutive transfers per grant (legal 2..255).
REQ-004 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: m0_req, m1_req  in  1  master requests bus.
REQ-007 SHALL have ports: m0_addr, m1_addr  in  AW  transfer address.
REQ-008 SHALL have ports: m0_wdata, m1_wdata  in  DW  write data.
REQ-009 SHALL have ports: m0_we, m1_we  in  1  1=write, 0=read.
REQ-010 SHALL have ports: m0_gnt, m1_gnt  out  1  registered grant.
REQ-011 SHALL have ports: m0_rvalid, m1_rvalid  out  1  read data valid for that master.
REQ-012 SHALL have ports: rdata  out  DW  read data, shared by both masters.
REQ-013 SHALL have ports: mem_addr  out  AW, mem_wdata  out  DW, mem_we  out  1  single-port RAM side.
REQ-014 SHALL have ports: mem_rdata  in  DW  RAM read data, valid one cycle after mem_addr.

Function
REQ-015 SHALL implement FSM states IDLE, OWN0, OWN1; m0_gnt=1 exactly in OWN0, m1_gnt=1 exactly in OWN1.
REQ-016 SHALL treat a transfer as any cycle with mxx_gnt=1 and mxx_req=1.
REQ-017 SHALL drive mem_addr/mem_wdata combinationally from the owning master; in IDLE, mem_addr=0 and mem_wdata=0.
REQ-018 SHALL assert mem_we only during a write transfer; never in IDLE or when the owner's req=0.
REQ-019 SHALL assert the owner's rvalid exactly one cycle after each read transfer, using a registered owner tag, including across an ownership change.
REQ-020 SHALL connect rdata directly to mem_rdata.
REQ-021 IDLE: one req -> that master's OWN state next cycle; both -> master not marked last-served; none -> stay IDLE.
REQ-022 OWNx with own req=0: switch directly to the other OWN state if the other master requests, else IDLE.
REQ-023 SHALL update last-served pointer on each entry to OWN0/OWN1.
REQ-024 SHALL give zero-cycle grant latency only while already owning; from IDLE, grant latency is exactly 1 cycle.
REQ-025 SHALL count transfers in the current ownership (8-bit); reset the counter on every entry to an OWN state; saturate and never wrap.

Reset
REQ-026 SHALL on rst=1, asynchronously: state=IDLE, m0_gnt=m1_gnt=0, m0_rvalid=m1_rvalid=0, mem_we=0, counter=0, last-served=m1, so m0 wins the first tie.
REQ-027 SHALL abort any transfer when rst asserts mid-operation; no rvalid is issued for that transfer after reset.

Configuration
REQ-028 SHALL honour macro ARB_BURST_LIMIT_EN.
REQ-029 With ARB_BURST_LIMIT_EN defined: when the owner completes its BURST_MAX-th transfer and the other master requests, SHALL switch to the other OWN state next cycle; the preempted master's gnt drops, and it must hold req.
REQ-030 Without ARB_BURST_LIMIT_EN: no preemption; the owner keeps the bus until it drops req; counter logic is absent.

Verification
REQ-031 m0 read 0x0010 alone from IDLE -> m0_gnt at cycle+1, mem_addr=0x0010, m0_rvalid at cycle+2 with rdata=RAM[0x0010].
REQ-032 m0_req and m1_req rise together after reset -> m0 granted; after m0 releases, m1 granted on the very next cycle, with no IDLE cycle.
REQ-033 m1 writes 0xBEEF to 0x0100 -> mem_we=1 exactly one cycle, RAM[0x0100]=0xBEEF; m0 reads it later and gets 0xBEEF.
REQ-034 ARB_BURST_LIMIT_EN, BURST_MAX=8, m0 holds req, m1 requests -> m0 gets exactly 8 transfers, then m1_gnt=1 and m0_gnt=0.
REQ-035 No macro, same stimulus -> m0 keeps the grant for 20+ cycles; m1_gnt stays 0.
REQ-036 rst pulsed while m1 is mid-read -> gnt/rvalid/mem_we go 0 immediately; the next tie after reset goes to m0.
